// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART TX arbitration slice.
//   UART_DATA_W : width of one serialized byte.
//   arb_state_t : state encoding of the transmit arbiter FSM.
//   tick_rise() : rising-edge detect of a free-running baud tick against
//                 its one-cycle-delayed copy.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } arb_state_t;

  function automatic logic tick_rise(input logic tick, input logic tick_q);
    return tick & ~tick_q;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req        in  NUM_REQ : request vector
//   last_grant in  IDX_W   : most recently released requester
//   gnt_idx    out IDX_W   : winner, searched from last_grant+1 upward (mod NUM_REQ)
//   gnt_valid  out 1       : at least one request present
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  // cand_idx[k] is the requester with search priority k (0 = highest).
  logic [IDX_W-1:0] cand_idx [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand_idx[gi] = IDX_W'((32'(last_grant) + 32'(gi) + 32'd1) % 32'(NUM_REQ));
    end
  endgenerate

  // Walk from lowest to highest priority so the highest-priority hit is
  // the last assignment and wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[cand_idx[i]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand_idx[i];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX serializer among NUM_REQ byte sources.
// Round-robin arbitration with an optional packet lock (a byte with Last=0
// keeps the grant, up to MAX_BURST bytes), then an idle gap of GAP_TICKS
// baud tick rising edges after each frame.
//   clk, reset_n          : system clock, asynchronous active-low reset
//   i_Req_Valid/Data/Last : per-requester byte offer (data at [8i+7:8i])
//   o_Req_Ready           : one-hot pop pulse on the serializer handshake
//   o_Tx_Valid/o_Tx_Data  : byte offered to the serializer
//   i_Tx_Ready            : serializer accepts on o_Tx_Valid & i_Tx_Ready
//   i_Tx_Done             : end-of-stop-bit pulse from the serializer
//   i_Tx_ClkTick          : toggling baud tick, rising edges counted in GAP
//   o_Grant_Idx           : current or last granted requester
//   o_Busy                : FSM not in IDLE
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  parameter int GAP_TICKS = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           i_Req_Valid,
  input  logic [NUM_REQ*UART_DATA_W-1:0] i_Req_Data,
  input  logic [NUM_REQ-1:0]           i_Req_Last,
  output logic [NUM_REQ-1:0]           o_Req_Ready,
  output logic                         o_Tx_Valid,
  output logic [UART_DATA_W-1:0]       o_Tx_Data,
  input  logic                         i_Tx_Ready,
  input  logic                         i_Tx_Done,
  input  logic                         i_Tx_ClkTick,
  output logic [$clog2(NUM_REQ)-1:0]   o_Grant_Idx,
  output logic                         o_Busy
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  // Keep at least one bit so the gap counter exists when the gap is disabled.
  localparam int GAP_W   = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  arb_state_t         state_reg;
  logic [IDX_W-1:0]   last_grant_reg;
  logic               lock_reg;
  logic [BURST_W-1:0] burst_cnt_reg;
  logic [GAP_W-1:0]   gap_cnt_reg;
  logic               tick_q_reg;

  logic [IDX_W-1:0]   rr_idx;
  logic               rr_valid;
  logic               lock_hold;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_valid;
  logic               tx_fire;
  logic               lock_next;
  logic               tick_rise_w;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (i_Req_Valid),
    .last_grant (last_grant_reg),
    .gnt_idx    (rr_idx),
    .gnt_valid  (rr_valid)
  );

  // A lock only survives while its owner keeps offering bytes; o_Grant_Idx
  // still holds the owner while the FSM sits in IDLE.
  assign lock_hold = lock_reg & i_Req_Valid[o_Grant_Idx];
  assign sel_idx   = lock_hold ? o_Grant_Idx : rr_idx;
  assign sel_valid = lock_hold | rr_valid;

  assign tx_fire   = (state_reg == ST_SEND) & i_Tx_Ready;
  // Lock is kept only for a non-final byte that still leaves room in the burst.
  assign lock_next = ~i_Req_Last[o_Grant_Idx] &
                     ((32'(burst_cnt_reg) + 32'd1) < 32'(MAX_BURST));
  assign tick_rise_w = tick_rise(i_Tx_ClkTick, tick_q_reg);

  assign o_Busy = (state_reg != ST_IDLE);

  always_comb begin
    o_Req_Ready = '0;
    if (tx_fire) begin
      o_Req_Ready[o_Grant_Idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= IDX_W'(NUM_REQ - 1);
      lock_reg       <= 1'b0;
      burst_cnt_reg  <= '0;
      gap_cnt_reg    <= '0;
      tick_q_reg     <= 1'b0;
      o_Tx_Valid     <= 1'b0;
      o_Tx_Data      <= '0;
      o_Grant_Idx    <= '0;
    end else begin
      tick_q_reg <= i_Tx_ClkTick;
      case (state_reg)
        ST_IDLE: begin
          if (lock_reg && !lock_hold) begin
            lock_reg      <= 1'b0;
            burst_cnt_reg <= '0;
          end
          if (sel_valid) begin
            o_Grant_Idx <= sel_idx;
            o_Tx_Data   <= i_Req_Data[sel_idx*UART_DATA_W +: UART_DATA_W];
            o_Tx_Valid  <= 1'b1;
            state_reg   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (i_Tx_Ready) begin
            o_Tx_Valid <= 1'b0;
            state_reg  <= ST_WAIT_DONE;
            lock_reg   <= lock_next;
            if (lock_next) begin
              burst_cnt_reg <= burst_cnt_reg + BURST_W'(1);
            end else begin
              // Release: the just-served requester drops to lowest priority.
              burst_cnt_reg  <= '0;
              last_grant_reg <= o_Grant_Idx;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (i_Tx_Done) begin
            state_reg <= (GAP_TICKS > 0) ? ST_GAP : ST_IDLE;
          end
        end
        ST_GAP: begin
          if (tick_rise_w) begin
            if ((32'(gap_cnt_reg) + 32'd1) >= 32'(GAP_TICKS)) begin
              gap_cnt_reg <= '0;
              state_reg   <= ST_IDLE;
            end else begin
              gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter.
// dut_a: NUM_REQ=4, MAX_BURST=16, GAP_TICKS=0 (single, round-robin, lock, reset).
// dut_b: NUM_REQ=4, MAX_BURST=2,  GAP_TICKS=2 (forced release, gap).
// Both share the stimulus; sel_b chooses which one the checks observe.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic        tx_ready;
  logic        tx_done;
  logic        tx_tick;

  logic [3:0]  a_req_ready, b_req_ready;
  logic        a_tx_valid,  b_tx_valid;
  logic [7:0]  a_tx_data,   b_tx_data;
  logic [1:0]  a_grant,     b_grant;
  logic        a_busy,      b_busy;

  uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(16), .GAP_TICKS(0)) dut_a (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_Req_Valid  (req_valid),
    .i_Req_Data   (req_data),
    .i_Req_Last   (req_last),
    .o_Req_Ready  (a_req_ready),
    .o_Tx_Valid   (a_tx_valid),
    .o_Tx_Data    (a_tx_data),
    .i_Tx_Ready   (tx_ready),
    .i_Tx_Done    (tx_done),
    .i_Tx_ClkTick (tx_tick),
    .o_Grant_Idx  (a_grant),
    .o_Busy       (a_busy)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(2), .GAP_TICKS(2)) dut_b (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_Req_Valid  (req_valid),
    .i_Req_Data   (req_data),
    .i_Req_Last   (req_last),
    .o_Req_Ready  (b_req_ready),
    .o_Tx_Valid   (b_tx_valid),
    .o_Tx_Data    (b_tx_data),
    .i_Tx_Ready   (tx_ready),
    .i_Tx_Done    (tx_done),
    .i_Tx_ClkTick (tx_tick),
    .o_Grant_Idx  (b_grant),
    .o_Busy       (b_busy)
  );

  logic       sel_b;
  logic [3:0] m_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic [1:0] m_grant;
  logic       m_busy;
  assign m_ready = sel_b ? b_req_ready : a_req_ready;
  assign m_valid = sel_b ? b_tx_valid  : a_tx_valid;
  assign m_data  = sel_b ? b_tx_data   : a_tx_data;
  assign m_grant = sel_b ? b_grant     : a_grant;
  assign m_busy  = sel_b ? b_busy      : a_busy;

  int checks = 0;
  int errors = 0;

  // Requester model: per-requester list of (byte, last), popped on grant.
  logic [7:0] qd [4][8];
  logic       ql [4][8];
  int         qn [4];
  int         qp [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      if (qp[i] < qn[i]) begin
        req_valid[i]        = 1'b1;
        req_data[8*i +: 8]  = qd[i][qp[i]];
        req_last[i]         = ql[i][qp[i]];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[8*i +: 8]  = 8'h00;
        req_last[i]         = 1'b1;
      end
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    qd[r][qn[r]] = d;
    ql[r][qn[r]] = l;
    qn[r]++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tx_done = 1'b0;
    tx_tick = 1'b0;
    for (int i = 0; i < 4; i++) begin
      qn[i] = 0;
      qp[i] = 0;
    end
    refresh();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Wait (bounded) for the observed DUT to offer a byte, check the pop
  // pulse, then let the handshake complete and pop the model.
  task automatic get_xfer(output int gidx, output int gd);
    logic seen;
    seen = 1'b0;
    gidx = -1;
    gd   = -1;
    for (int n = 0; n < 20; n++) begin
      if (m_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("xfer_seen", 32'(seen), 32'd1);
    if (seen) begin
      gidx = int'(m_grant);
      gd   = int'(m_data);
      chk("ready_onehot", 32'(m_ready), 32'(4'b0001 << m_grant));
      $display("xfer dut=%s grant=%0d data=0x%02h", sel_b ? "b" : "a", gidx, gd);
      @(negedge clk);
      chk("ready_clear", 32'(m_ready), 32'd0);
      if (qp[gidx] < qn[gidx]) qp[gidx]++;
      refresh();
    end
  endtask

  task automatic pulse_done(input int rises);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    for (int r = 0; r < rises; r++) begin
      tx_tick = 1'b1;
      @(negedge clk);
      tx_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  int g, d;
  int exp_g [5];
  int exp_d [5];

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '1;
    tx_ready  = 1'b1;
    tx_done   = 1'b0;
    tx_tick   = 1'b0;
    sel_b     = 1'b0;

    // Reset state
    do_reset();
    chk("rst_tx_valid", 32'(a_tx_valid), 32'd0);
    chk("rst_tx_data",  32'(a_tx_data),  32'd0);
    chk("rst_ready",    32'(a_req_ready), 32'd0);
    chk("rst_grant",    32'(a_grant),    32'd0);
    chk("rst_busy",     32'(a_busy),     32'd0);

    // Single requester: 2 sends 0xA5, one-cycle grant latency
    push(2, 8'hA5, 1'b1);
    refresh();
    chk("single_pre_valid", 32'(a_tx_valid), 32'd0);
    @(negedge clk);
    chk("single_valid", 32'(a_tx_valid),  32'd1);
    chk("single_data",  32'(a_tx_data),   32'h0A5);
    chk("single_ready", 32'(a_req_ready), 32'b0100);
    chk("single_grant", 32'(a_grant),     32'd2);
    chk("single_busy",  32'(a_busy),      32'd1);
    @(negedge clk);
    chk("single_ready_once", 32'(a_req_ready), 32'd0);
    chk("single_valid_drop", 32'(a_tx_valid),  32'd0);
    qp[2]++;
    refresh();
    pulse_done(0);
    chk("single_idle", 32'(a_busy), 32'd0);

    // Round-robin: all four valid, single-byte packets
    do_reset();
    push(0, 8'h10, 1'b1); push(0, 8'h11, 1'b1);
    push(1, 8'h20, 1'b1);
    push(2, 8'h30, 1'b1);
    push(3, 8'h40, 1'b1);
    refresh();
    exp_g = '{0, 1, 2, 3, 0};
    exp_d = '{'h10, 'h20, 'h30, 'h40, 'h11};
    for (int k = 0; k < 5; k++) begin
      get_xfer(g, d);
      chk($sformatf("rr_grant%0d", k), 32'(g), 32'(exp_g[k]));
      chk($sformatf("rr_data%0d", k),  32'(d), 32'(exp_d[k]));
      pulse_done(0);
    end

    // Packet lock: requester 1 sends 3 bytes, requester 0 joins after the first
    do_reset();
    push(1, 8'h21, 1'b0); push(1, 8'h22, 1'b0); push(1, 8'h23, 1'b1);
    refresh();
    exp_g = '{1, 1, 1, 0, 0};
    exp_d = '{'h21, 'h22, 'h23, 'h01, 0};
    for (int k = 0; k < 4; k++) begin
      get_xfer(g, d);
      chk($sformatf("lock_grant%0d", k), 32'(g), 32'(exp_g[k]));
      chk($sformatf("lock_data%0d", k),  32'(d), 32'(exp_d[k]));
      if (k == 0) begin
        push(0, 8'h01, 1'b1);
        refresh();
      end
      pulse_done(0);
    end

    // Forced release (MAX_BURST=2): grants 3,3,0,3,3
    sel_b = 1'b1;
    do_reset();
    push(3, 8'h31, 1'b0); push(3, 8'h32, 1'b0); push(3, 8'h33, 1'b0);
    push(3, 8'h34, 1'b0); push(3, 8'h35, 1'b0);
    refresh();
    exp_g = '{3, 3, 0, 3, 3};
    exp_d = '{'h31, 'h32, 'h01, 'h33, 'h34};
    for (int k = 0; k < 5; k++) begin
      get_xfer(g, d);
      chk($sformatf("force_grant%0d", k), 32'(g), 32'(exp_g[k]));
      chk($sformatf("force_data%0d", k),  32'(d), 32'(exp_d[k]));
      if (k == 0) begin
        push(0, 8'h01, 1'b1);
        refresh();
      end
      pulse_done(2);
    end

    // Gap (GAP_TICKS=2): a rise coincident with Done is not counted
    do_reset();
    push(0, 8'h50, 1'b1);
    refresh();
    get_xfer(g, d);
    chk("gap_first_grant", 32'(g), 32'd0);
    chk("gap_first_data",  32'(d), 32'h50);
    push(1, 8'h51, 1'b1);
    refresh();
    tx_done = 1'b1;
    tx_tick = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("gap_enter_busy",  32'(b_busy),     32'd1);
    chk("gap_enter_valid", 32'(b_tx_valid), 32'd0);
    tx_tick = 1'b0;
    @(negedge clk);
    tx_tick = 1'b1;
    @(negedge clk);
    chk("gap_rise1_busy",  32'(b_busy),     32'd1);
    chk("gap_rise1_valid", 32'(b_tx_valid), 32'd0);
    tx_tick = 1'b0;
    @(negedge clk);
    chk("gap_low_busy", 32'(b_busy), 32'd1);
    tx_tick = 1'b1;
    @(negedge clk);
    chk("gap_rise2_busy",  32'(b_busy),     32'd0);
    chk("gap_rise2_valid", 32'(b_tx_valid), 32'd0);
    @(negedge clk);
    chk("gap_next_valid", 32'(b_tx_valid), 32'd1);
    chk("gap_next_grant", 32'(b_grant),    32'd1);
    chk("gap_next_data",  32'(b_tx_data),  32'h51);

    // Reset mid-frame: reset in WAIT_DONE, then requester 0 has first priority
    sel_b = 1'b0;
    do_reset();
    push(2, 8'h62, 1'b1);
    refresh();
    get_xfer(g, d);
    chk("mid_grant", 32'(g), 32'd2);
    chk("mid_busy",  32'(a_busy), 32'd1);
    reset_n = 1'b0;
    push(0, 8'h70, 1'b1);
    push(3, 8'h73, 1'b1);
    refresh();
    @(negedge clk);
    chk("mid_rst_valid", 32'(a_tx_valid),  32'd0);
    chk("mid_rst_data",  32'(a_tx_data),   32'd0);
    chk("mid_rst_ready", 32'(a_req_ready), 32'd0);
    chk("mid_rst_grant", 32'(a_grant),     32'd0);
    chk("mid_rst_busy",  32'(a_busy),      32'd0);
    reset_n = 1'b1;
    get_xfer(g, d);
    chk("mid_after_grant", 32'(g), 32'd0);
    chk("mid_after_data",  32'(d), 32'h70);
    pulse_done(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
